// File: rtl/display_pkg.sv
// Shared encodings for the 4-digit multiplexed 7-segment bus (gfedcba, all active-low).
// Used by the display driver and the scan monitor.
package display_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;
  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  localparam logic [3:0] AN_DIG0  = 4'b1110;
  localparam logic [3:0] AN_DIG1  = 4'b1101;
  localparam logic [3:0] AN_DIG2  = 4'b1011;
  localparam logic [3:0] AN_DIG3  = 4'b0111;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  typedef struct packed {
    logic [15:0] dat;
    logic [1:0]  ptr;
    logic        ptr_vld;
    logic        seg_err;
  } frame_t;

endpackage

// File: rtl/display_scan_monitor_seg7_decode.sv
// Combinational 7-segment (gfedcba, active-low) to hex nibble decoder.
// hit is low for any pattern outside the hex table; nibble is then 0.
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] SEG,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (SEG)
      SEG_HEX_0: nibble = 4'h0;
      SEG_HEX_1: nibble = 4'h1;
      SEG_HEX_2: nibble = 4'h2;
      SEG_HEX_3: nibble = 4'h3;
      SEG_HEX_4: nibble = 4'h4;
      SEG_HEX_5: nibble = 4'h5;
      SEG_HEX_6: nibble = 4'h6;
      SEG_HEX_7: nibble = 4'h7;
      SEG_HEX_8: nibble = 4'h8;
      SEG_HEX_9: nibble = 4'h9;
      SEG_HEX_A: nibble = 4'hA;
      SEG_HEX_B: nibble = 4'hB;
      SEG_HEX_C: nibble = 4'hC;
      SEG_HEX_D: nibble = 4'hD;
      SEG_HEX_E: nibble = 4'hE;
      SEG_HEX_F: nibble = 4'hF;
      default:   hit    = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_scan_monitor.sv
// Decodes a scanned 4-digit 7-segment bus back into 16-bit frames with point position.
// Frame pulse arrives 1 + SETTLE + 1 cycles after the completing dwell starts at the pins.
module display_scan_monitor
  import display_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  AN,
  input  logic [6:0]  SEG,
  input  logic        seg_P,
  output logic [15:0] DAT,
  output logic [1:0]  PTR,
  output logic        frm_vld,
  output logic        ptr_vld,
  output logic        seg_err,
  output logic        an_err
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [3:0]      r_an_q;
  logic [3:0]      r_an_prev;
  logic [6:0]      r_seg_q;
  logic            r_p_q;
  logic [3:0]      r_cnt;
  logic [3:0][3:0] r_slot;
  logic [3:0]      r_seen;
  logic [3:0]      r_pt;
  logic            r_err_acc;

  logic [3:0]      w_nib;
  logic            w_hit;
  logic            w_stable;
  logic            w_sample;
  logic            w_onehot;
  logic [1:0]      w_idx;
  logic [3:0][3:0] w_slot_nxt;
  logic [3:0]      w_seen_nxt;
  logic [3:0]      w_pt_nxt;
  logic            w_err_nxt;
  logic            w_done;
  logic [1:0]      w_ptr;
  logic            w_one_pt;

  seg7_decode u_dec (
    .SEG    (r_seg_q),
    .nibble (w_nib),
    .hit    (w_hit)
  );

  // One sample per dwell: fires only on the cycle the counter would step onto SETTLE.
  assign w_stable = (r_an_q == r_an_prev);
  assign w_sample = w_stable && (r_cnt == SETTLE_C - 4'd1);

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_an_q)
      AN_DIG0: w_idx = 2'd0;
      AN_DIG1: w_idx = 2'd1;
      AN_DIG2: w_idx = 2'd2;
      AN_DIG3: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  always_comb begin
    w_slot_nxt = r_slot;
    w_seen_nxt = r_seen;
    w_pt_nxt   = r_pt;
    w_err_nxt  = r_err_acc;
    if (w_sample && w_onehot) begin
      w_slot_nxt[w_idx] = w_hit ? w_nib : 4'h0;
      w_seen_nxt[w_idx] = 1'b1;
      w_pt_nxt[w_idx]   = !r_p_q;
      if (!w_hit) begin
        w_err_nxt = 1'b1;
      end
    end
  end

  assign w_done   = w_sample && w_onehot && (w_seen_nxt == 4'b1111);
  assign w_one_pt = (w_pt_nxt != 4'd0) && ((w_pt_nxt & (w_pt_nxt - 4'd1)) == 4'd0);

  always_comb begin
    w_ptr = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pt_nxt[i]) begin
        w_ptr = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an_q    <= AN_BLANK;
      r_an_prev <= AN_BLANK;
      r_seg_q   <= SEG_OFF;
      r_p_q     <= 1'b1;
      r_cnt     <= 4'd0;
      r_slot    <= '0;
      r_seen    <= 4'd0;
      r_pt      <= 4'd0;
      r_err_acc <= 1'b0;
      DAT       <= 16'h0000;
      PTR       <= 2'd0;
      frm_vld   <= 1'b0;
      ptr_vld   <= 1'b0;
      seg_err   <= 1'b0;
      an_err    <= 1'b0;
    end else begin
      r_an_q    <= AN;
      r_an_prev <= r_an_q;
      r_seg_q   <= SEG;
      r_p_q     <= seg_P;
      if (!w_stable) begin
        r_cnt <= 4'd0;
      end else if (r_cnt < SETTLE_C) begin
        r_cnt <= r_cnt + 4'd1;
      end
      an_err  <= w_sample && !w_onehot;
      frm_vld <= w_done;
      r_slot  <= w_slot_nxt;
      if (w_done) begin
        DAT       <= w_slot_nxt;
        PTR       <= w_ptr;
        ptr_vld   <= w_one_pt;
        seg_err   <= w_err_nxt;
        r_seen    <= 4'd0;
        r_pt      <= 4'd0;
        r_err_acc <= 1'b0;
      end else begin
        r_seen    <= w_seen_nxt;
        r_pt      <= w_pt_nxt;
        r_err_acc <= w_err_nxt;
      end
    end
  end

endmodule

// File: doc/display_scan_monitor.md
Name: display_scan_monitor

Overview:
- Receiver end of our 4-digit multiplexed 7-segment display bus (AN active-low one-hot digit enable, SEG gfedcba active-low, seg_P active-low point).
- Watches the scanned bus, waits for each digit dwell to settle, and decodes the segment pattern back to a hex nibble.
- Reassembles the 16-bit word and the point position, and reports each complete frame.
- Used for loopback self-test of display drivers on the board and as a bench monitor.

Parameters:
- SETTLE, 2, number of consecutive clk cycles a registered AN value must stay unchanged before the dwell is sampled (legal range 1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- AN  input  4  digit enables, active-low; bit k low selects digit k.
- SEG  input  7  segments gfedcba, active-low.
- seg_P  input  1  decimal point, active-low.
- DAT  output  16  last complete frame; digit k is in DAT[4k+3:4k].
- PTR  output  2  index of the digit whose point was lit in the last frame.
- frm_vld  output  1  one-cycle pulse; DAT, PTR, ptr_vld and seg_err were updated this cycle.
- ptr_vld  output  1  last frame had exactly one lit point.
- seg_err  output  1  last frame contained at least one undecodable SEG pattern.
- an_err  output  1  one-cycle pulse when a settled AN is not exactly one zero bit.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - DAT=0, PTR=0, frm_vld=0, ptr_vld=0, seg_err=0, an_err=0.
  - All internal slots, seen mask, point flags, error accumulator and settle counter are cleared.
  - Input registers load 4'b1111 / 7'h7F / 1.
  - Reset mid-frame discards the partial frame.
- Input stage: AN, SEG and seg_P are registered once (an_q, seg_q, p_q). All logic below uses the registered values.
- Settle counter cnt (4 bits):
  - Cleared to 0 when an_q differs from its previous-cycle value.
  - Otherwise increments, saturating at SETTLE.
  - A sample event fires in the cycle cnt reaches SETTLE: exactly once per dwell, regardless of dwell length.
- On a sample event:
  - an_q not one-hot-low (including 4'b1111 blanking and multiple zeros): an_err=1 on the next cycle; no slot, seen bit or point flag changes.
  - an_q one-hot-low with index k:
    - slot[k] <= decode(seg_q), seen[k] <= 1, pt[k] <= !p_q.
    - If seg_q matches no table entry: slot[k] <= 0 and err_acc <= 1.
    - A repeated index before frame completion overwrites slot[k] and pt[k]; err_acc is never cleared by an overwrite.
- Frame completion: when the sample event makes seen == 4'b1111, the next cycle has:
  - frm_vld=1 and DAT = {slot3, slot2, slot1, slot0}, including the slot just written.
  - ptr_vld = 1 iff exactly one pt bit is set.
  - PTR = lowest index with pt set; PTR = 0 if none is set.
  - seg_err = err_acc including the current sample.
  - seen, pt and err_acc are cleared in that same cycle.
- Outputs hold between frames. frm_vld and an_err are single-cycle.
- Latency: AN/SEG change at the pins to frm_vld is 1 (input reg) + SETTLE + 1 cycles for the completing dwell.
- Decode table (SEG to nibble), gfedcba active-low:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- SEG is assumed stable while AN is stable; a SEG change inside a dwell after the sample is ignored.
- Digit order is free: any order that covers all four indices completes a frame.

Decomposition:
- Shared package display_pkg:
  - 16 SEG pattern constants (SEG_HEX_0..SEG_HEX_F).
  - AN one-hot-low constants (AN_DIG0..AN_DIG3) and AN_BLANK = 4'b1111.
  - Also used by the existing display driver.
- One combinational sub-module seg7_decode: input SEG[6:0], outputs nibble[3:0] and hit.
- Settle counter, slots and frame assembly stay in the top module.

Test Plan:
- Reset then drive the scan 0→1→2→3 with DAT=16'h1234, point on digit 2, dwell 8 cycles → one frm_vld pulse; DAT=16'h1234, PTR=2, ptr_vld=1, seg_err=0.
- Full hex sweep: frames 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF with no point → each frame decoded exactly; ptr_vld=0, PTR=0.
- Digit 1 dwell with SEG=7'b1111111 inside frame 16'hA5A5 → frm_vld with DAT=16'hA500 | slots 0,2,3 (i.e. 16'hA505), seg_err=1; the next clean frame gives seg_err=0.
- AN=4'b1100 held 5 cycles, then AN=4'b1111 → an_err pulses once per dwell; no frame and no slot change; the subsequent valid scan completes normally.
- Glitch: AN changes after SETTLE-1 stable cycles → no sample. Dwell of exactly SETTLE+1 cycles → exactly one sample. A 100-cycle dwell → still one sample.
- Assert rst_n=0 after digits 0 and 1 are sampled, release, then scan 2,3,0,1 → first frm_vld only after all four post-reset dwells; DAT contains only post-reset values.
